// File: rtl/karatsuba_mac_stage_pkg.sv
// Shared types and constants for the Karatsuba multiply-accumulate stage.
package karatsuba_mac_stage_pkg;

  localparam int OP_W   = 16;
  localparam int PROD_W = 32;

  typedef enum logic [1:0] {
    ACC   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/karatsuba_mac_stage.sv
// Multiply-accumulate stage downstream of the combinational Karatsuba multiplier.
// Registers operand pairs onto the multiplier inputs (S0), captures the product
// one edge later (S1), and accumulates products over a burst ending with in_last.
module karatsuba_mac_stage
  import karatsuba_mac_stage_pkg::*;
#(
  parameter int ACC_W = 40,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_x,
  input  logic [OP_W-1:0]   in_y,
  input  logic              in_last,
  output logic [OP_W-1:0]   mult_x,
  output logic [OP_W-1:0]   mult_y,
  input  logic [PROD_W-1:0] mult_z,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_acc,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_ovf
);

  state_e state_q, state_d;

  logic              accept;
  logic              finish;

  logic              s0_valid_q, s0_last_q;
  logic [OP_W-1:0]   mult_x_q, mult_y_q;

  logic              s1_valid_q, s1_last_q;
  logic [PROD_W-1:0] prod_q;

  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d;

  logic [ACC_W:0]    sum;
  logic [ACC_W-1:0]  acc_upd;
  logic [CNT_W-1:0]  cnt_upd;
  logic              ovf_upd;

  logic [ACC_W-1:0]  out_acc_q, out_acc_d;
  logic [CNT_W-1:0]  out_count_q, out_count_d;
  logic              out_ovf_q, out_ovf_d;
  logic              out_valid_q;

  assign in_ready  = (state_q == ACC);
  assign accept    = in_valid & in_ready;
  assign finish    = s1_valid_q & s1_last_q;

  assign mult_x    = mult_x_q;
  assign mult_y    = mult_y_q;
  assign out_valid = out_valid_q;
  assign out_acc   = out_acc_q;
  assign out_count = out_count_q;
  assign out_ovf   = out_ovf_q;

  // S0: capture accepted operands; they drive the multiplier directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_valid_q <= 1'b0;
      s0_last_q  <= 1'b0;
      mult_x_q   <= '0;
      mult_y_q   <= '0;
    end else begin
      s0_valid_q <= accept;
      if (accept) begin
        s0_last_q <= in_last;
        mult_x_q  <= in_x;
        mult_y_q  <= in_y;
      end
    end
  end

  // S1: capture the multiplier product alongside its valid/last tags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      prod_q     <= '0;
    end else begin
      s1_valid_q <= s0_valid_q;
      if (s0_valid_q) begin
        s1_last_q <= s0_last_q;
        prod_q    <= mult_z;
      end
    end
  end

  // Accumulator datapath: widened add exposes the carry for the sticky flag.
  always_comb begin
    sum     = {1'b0, acc_q} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod_q};
    acc_upd = sum[ACC_W-1:0];
    ovf_upd = ovf_q | sum[ACC_W];
    cnt_upd = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_acc_d   = out_acc_q;
    out_count_d = out_count_q;
    out_ovf_d   = out_ovf_q;

    if (s1_valid_q) begin
      if (s1_last_q) begin
        // Result leaves with the final beat folded in; the internal sums
        // restart from zero so the next burst never sees this one.
        out_acc_d   = acc_upd;
        out_count_d = cnt_upd;
        out_ovf_d   = ovf_upd;
        acc_d       = '0;
        cnt_d       = '0;
        ovf_d       = 1'b0;
      end else begin
        acc_d = acc_upd;
        cnt_d = cnt_upd;
        ovf_d = ovf_upd;
      end
    end
  end

  // Accumulator and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_acc_q   <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_acc_q   <= out_acc_d;
      out_count_q <= out_count_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  // FSM next-state: stop accepting after last, hold result until consumed.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ACC:     if (accept && in_last) state_d = DRAIN;
      DRAIN:   if (finish)            state_d = DONE;
      DONE:    if (out_ready)         state_d = ACC;
      default:                        state_d = ACC;
    endcase
  end

  // FSM state register; out_valid is registered as "next state is DONE".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACC;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= (state_d == DONE);
    end
  end

endmodule

// File: tb/tb_karatsuba_mac_stage.sv
// Self-checking bench for karatsuba_mac_stage with a behavioural multiplier
// sibling and a burst-level sum model.
module tb_karatsuba_mac_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_x = '0;
  logic [15:0] in_y = '0;
  logic        in_last = 1'b0;
  logic [15:0] mult_x, mult_y;
  logic [31:0] mult_z;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [39:0] out_acc;
  logic [7:0]  out_count;
  logic        out_ovf;

  int passes = 0;
  int total  = 0;

  logic [15:0] qx[$];
  logic [15:0] qy[$];

  karatsuba_mac_stage #(.ACC_W(40), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_y      (in_y),
    .in_last   (in_last),
    .mult_x    (mult_x),
    .mult_y    (mult_y),
    .mult_z    (mult_z),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_acc   (out_acc),
    .out_count (out_count),
    .out_ovf   (out_ovf)
  );

  // Sibling combinational multiplier.
  assign mult_z = 32'(mult_x) * 32'(mult_y);

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Present one beat at a negedge and return at the negedge after it is taken.
  task automatic send(input logic [15:0] x, input logic [15:0] y, input logic last);
    int w = 0;
    in_valid = 1'b1;
    in_x     = x;
    in_y     = y;
    in_last  = last;
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (w >= 50) check("send_wait", 64'(w), 64'd0);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Drive the queued burst and check the result against plain arithmetic.
  task automatic run_burst(input string name, input int gap, input int hold);
    longint unsigned sum = 0;
    int n = qx.size();
    int k = 0;
    bit rdy_low = 1'b1;
    bit stable = 1'b1;
    logic [39:0] e_acc;
    logic [7:0]  e_cnt;
    logic        e_ovf;
    for (int i = 0; i < n; i++) begin
      sum += 64'(qx[i]) * 64'(qy[i]);
      send(qx[i], qy[i], i == n - 1);
      if (i < n - 1) repeat (gap) @(negedge clk);
    end
    e_acc = sum[39:0];
    e_ovf = (sum >> 40) != 0;
    e_cnt = (n > 255) ? 8'd255 : 8'(n);
    while (!out_valid && k < 400) begin
      if (in_ready) rdy_low = 1'b0;
      @(negedge clk);
      k++;
    end
    if (in_ready) rdy_low = 1'b0;
    check({name, "_latency"}, 64'(k), 64'd2);
    check({name, "_in_ready_low"}, 64'(rdy_low), 64'd1);
    check({name, "_acc"}, 64'(out_acc), 64'(e_acc));
    check({name, "_count"}, 64'(out_count), 64'(e_cnt));
    check({name, "_ovf"}, 64'(out_ovf), 64'(e_ovf));
    if (hold > 0) begin
      repeat (hold) begin
        @(negedge clk);
        if (!out_valid || in_ready || out_acc !== e_acc || out_count !== e_cnt
            || out_ovf !== e_ovf) stable = 1'b0;
      end
      check({name, "_hold"}, 64'(stable), 64'd1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({name, "_released_valid"}, 64'(out_valid), 64'd0);
    check({name, "_released_ready"}, 64'(in_ready), 64'd1);
    qx.delete();
    qy.delete();
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_acc", 64'(out_acc), 64'd0);
    check("rst_out_count", 64'(out_count), 64'd0);
    check("rst_out_ovf", 64'(out_ovf), 64'd0);
    check("rst_mult_x", 64'(mult_x), 64'd0);
    check("rst_mult_y", 64'(mult_y), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single beat, plus operand registers visible one cycle after accept.
    send(16'd3, 16'd5, 1'b1);
    check("single_mult_x", 64'(mult_x), 64'd3);
    check("single_mult_y", 64'(mult_y), 64'd5);
    // Previous task already consumed the first wait cycle; rebuild from scratch.
    k_wait_single();

    // Back-to-back all-ones burst.
    repeat (4) begin qx.push_back(16'hFFFF); qy.push_back(16'hFFFF); end
    run_burst("b2b", 0, 0);

    // Wrap-around and count saturation.
    repeat (257) begin qx.push_back(16'hFFFF); qy.push_back(16'hFFFF); end
    run_burst("ovf_sat", 0, 1);

    // Bubbles between beats and result backpressure.
    qx = '{16'd2, 16'd4, 16'd6};
    qy = '{16'd3, 16'd5, 16'd7};
    run_burst("bubbles", 2, 5);
    qx.push_back(16'd1); qy.push_back(16'd1);
    run_burst("after_bp", 0, 0);

    // Asynchronous reset in the middle of a burst.
    send(16'd100, 16'd100, 1'b0);
    send(16'd200, 16'd200, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_out_acc", 64'(out_acc), 64'd0);
    check("midrst_out_count", 64'(out_count), 64'd0);
    check("midrst_mult_x", 64'(mult_x), 64'd0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    qx.push_back(16'd7); qy.push_back(16'd8);
    run_burst("post_rst", 0, 0);

    // Zero operands on either side.
    qx = '{16'd0, 16'hFFFF};
    qy = '{16'hFFFF, 16'd0};
    run_burst("zeros", 1, 0);

    // Randomized bursts with occasional extreme operands.
    for (int b = 0; b < 8; b++) begin
      int len = int'($urandom_range(1, 8));
      for (int i = 0; i < len; i++) begin
        qx.push_back(($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom));
        qy.push_back(($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom));
      end
      run_burst($sformatf("rand%0d", b), int'($urandom_range(0, 2)),
                int'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

  // Single-beat result: one more cycle to out_valid, then check and release.
  task automatic k_wait_single();
    int k = 1;
    bit rdy_low = !in_ready;
    while (!out_valid && k < 400) begin
      @(negedge clk);
      k++;
      if (in_ready) rdy_low = 1'b0;
    end
    check("single_latency", 64'(k), 64'd3);
    check("single_in_ready_low", 64'(rdy_low), 64'd1);
    check("single_acc", 64'(out_acc), 64'd15);
    check("single_count", 64'(out_count), 64'd1);
    check("single_ovf", 64'(out_ovf), 64'd0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("single_released_valid", 64'(out_valid), 64'd0);
  endtask

endmodule

// File: doc/karatsuba_mac_stage.md
Name: karatsuba_mac_stage

Overview:
- Sequential multiply-accumulate stage placed directly downstream of the 16-bit combinational Karatsuba multiplier.
- Accepts a valid/ready stream of 16x16 unsigned operand pairs and registers them to drive the multiplier inputs.
- Captures the 32-bit product one cycle later and accumulates products over a burst that ends with in_last.
- Presents the burst sum, beat count and overflow flag on a valid/ready output.

Parameters:
ACC_W, 40, accumulator/result width in bits; must be >= 32.
CNT_W, 8, beat-counter width; the counter saturates at 2^CNT_W-1.

Ports:
clk  in  1  single clock, rising edge.
rst_n  in  1  asynchronous, active-low reset.
in_valid  in  1  operand beat valid.
in_ready  out  1  stage can accept a beat.
in_x  in  16  unsigned multiplicand.
in_y  in  16  unsigned multiplier.
in_last  in  1  final beat of the burst; always carries data (no empty bursts).
mult_x  out  16  registered operand to the multiplier X input.
mult_y  out  16  registered operand to the multiplier Y input.
mult_z  in  32  product returned from the multiplier Z output (combinational from mult_x/mult_y).
out_valid  out  1  result valid.
out_ready  in  1  consumer accepts the result.
out_acc  out  ACC_W  burst sum of products, modulo 2^ACC_W.
out_count  out  CNT_W  beats in the burst, saturating.
out_ovf  out  1  sticky: accumulator carried out of ACC_W during the burst.

Behaviour:
- One clock domain. Reset is asynchronous and active-low.
- Reset state: state=ACC; in_ready=1; out_valid=0; out_acc, out_count, out_ovf, mult_x, mult_y=0; all pipeline valid bits=0. Asserting reset mid-operation discards every in-flight beat and any pending result.
- Pipeline:
  - Stage S0: on accept (in_valid & in_ready), register in_x, in_y, in_last and a valid bit. mult_x/mult_y are these registers.
  - Stage S1: next edge, capture mult_z, the last bit and the valid bit.
  - Accumulate: when S1 is valid, acc <= acc + p. Compute the sum in ACC_W+1 bits; the carry bit ORs into sticky ovf. cnt increments, holding at max.
- Throughput: one beat per cycle in ACC. No bubbles are required between beats.
- Latency: a last beat accepted in cycle n gives out_valid=1 in cycle n+3. out_acc includes that beat.
- FSM:
  - ACC: in_ready=1. Accepting a beat with in_last=1 moves to DRAIN.
  - DRAIN: in_ready=0. When the last beat is accumulated, load the out_* registers from the updated acc/cnt/ovf, clear the internal acc/cnt/ovf, set out_valid, and move to DONE.
  - DONE: in_ready=0, out_valid=1. out_acc, out_count and out_ovf hold stable until out_valid & out_ready. On that handshake, out_valid goes to 0 and the state returns to ACC.
- Clearing the internal accumulator on entry to DONE means no beat from a new burst ever mixes with the previous result.
- out_ready is ignored while out_valid=0.
- in_valid low mid-burst inserts bubbles; the pipeline valid bits gate accumulation, so idle cycles never add mult_z.
- Wrap-around: acc wraps modulo 2^ACC_W; out_ovf reports that a wrap occurred. The count saturates and does not wrap.
- in_x, in_y and in_last are don't-care when in_valid=0.

Decomposition:
- Shared package holds:
  - FSM state enum {ACC, DRAIN, DONE}, 2-bit encoded.
  - Constants OP_W=16 and PROD_W=32.
- No sub-module is instantiated inside this block; the multiplier stays a sibling at the parent level, connected through mult_x/mult_y/mult_z.
- An optional leaf, mac_accum_reg, holds the ACC_W adder, sticky ovf and saturating count.

Test Plan:
1. Single beat: in_x=3, in_y=5, in_last=1 accepted in cycle n -> out_valid in cycle n+3, out_acc=15, out_count=1, out_ovf=0; in_ready=0 during cycles n+1..handshake.
2. Back-to-back burst: 4 beats of 0xFFFF*0xFFFF on consecutive cycles, last on the 4th -> out_acc=0x3FFF80004, out_count=4, out_ovf=0.
3. Overflow and saturation: 257 beats of 0xFFFF*0xFFFF with default parameters -> out_acc=0x00FDFE0101, out_ovf=1, out_count=255.
4. Backpressure and bubbles: a burst (2,3),(4,5),(6,7) with in_valid low for 2 cycles between beats -> out_acc=68, out_count=3. Holding out_ready=0 for 5 cycles keeps out_valid=1, out_acc=68 and in_ready=0. A following single beat (1,1) then gives out_acc=1.
5. Reset mid-burst: accept (100,100) and (200,200) without last, pulse rst_n low asynchronously between edges -> all outputs 0 immediately and in_ready=1. A new burst (7,8,last) then gives out_acc=56, out_count=1.
6. Zero operands: (0,0xFFFF),(0xFFFF,0),last -> out_acc=0, out_count=2, out_ovf=0.
